priority_arbiter: RTL and testbench
===================================

# priority_arbiter

Registered, parametrised N-channel arbiter. It is the clocked successor to the 16-bit combinational priority resolver. It supports two modes, selectable at run time: fixed priority (channel 0 highest) and round-robin. A grant stays locked to its owner for as long as the owner keeps requesting. It sits between the per-channel request sources and the shared resource they contend for.

## Interface
- `N_CH`, default 16: number of request channels; legal range is ≥2.
- `HOLD_MAX`, default 64: maximum cycles one owner may hold the grant while others wait. Only used with `ARB_HOLD_TIMEOUT_EN`; legal range is ≥1.
- `Clk`, input, 1: the block's one clock; rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `requestSignals`, input, N_CH: one request bit per channel; level-sensitive.
- `roundRobin`, input, 1: 1 selects round-robin, 0 selects fixed priority. Sampled only at arbitration points.
- `grantSignals`, output, N_CH: registered one-hot grant, or all zeros.
- `grantValid`, output, 1: equals OR of `grantSignals`.
- `grantIndex`, output, IW: index of the current owner, where IW = max(1, $clog2(N_CH)). Holds 0 when `grantValid` is 0.
- `timeoutPulse`, output, 1: one-cycle pulse when a hold is forcibly revoked. Constant 0 when the timeout feature is compiled out.

## Operation
- **States:**
  - IDLE: no owner.
  - GRANT: owner is `grantIndex`.
- **Arbitration point:** any edge where the block is in IDLE, or in GRANT with `requestSignals[owner]` = 0, or at timeout revoke.
- **Winner selection:**
  - Fixed mode: the lowest-index asserted request.
  - Round-robin mode: search starts at `rrPtr` and goes upward, wrapping N_CH-1 → 0. The first asserted request wins.
- **`rrPtr`:** internal, IW bits. On every new grant to channel k, `rrPtr` ← (k+1) mod N_CH, in both modes. Fixed mode ignores it. Wrap at N_CH-1 gives 0, including for non-power-of-2 N_CH.
- **IDLE transitions:**
  - Any request asserted: go to GRANT with the winner.
  - Otherwise: stay in IDLE.
- **GRANT transitions:**
  - Owner request still high: hold. No re-arbitration, even if a higher-priority channel asserts.
  - Owner request low and others pending: hand off directly to the new winner with no idle bubble.
  - Owner request low and none pending: go to IDLE.
- A change to `roundRobin` mid-hold takes effect only at the next arbitration point.
- **Reset:** asynchronous and effective mid-operation.
  - Outputs: `grantSignals`=0, `grantValid`=0, `grantIndex`=0, `timeoutPulse`=0.
  - Internal: state=IDLE, `rrPtr`=0, hold counter=0.

## Timing
- Request-to-grant latency is 1 cycle. A request sampled at edge t gives a grant visible after edge t.
- A drop of the owner's request at edge t moves the grant after edge t. The next owner is active in the same cycle, with no overlap and no gap.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- A request asserted and dropped between edges is never seen.

## Configuration
- **`ARB_HOLD_TIMEOUT_EN` defined:**
  - A hold counter, width $clog2(HOLD_MAX+1), clears on each new grant and increments each cycle in GRANT.
  - When the counter reaches HOLD_MAX and another channel requests, the next edge re-arbitrates with the owner excluded. `timeoutPulse` is 1 for that cycle. `rrPtr` updates as for any grant.
  - With no other requester, the counter saturates at HOLD_MAX and the owner keeps the grant.
- **`ARB_HOLD_TIMEOUT_EN` undefined:**
  - No counter is built. Holds are unbounded and `timeoutPulse` is tied to 0.

## Structure
- Package `priority_arbiter_pkg`:
  - state enum {IDLE, GRANT}.
  - an index-width function (max(1, $clog2(n))).
  - a one-hot-to-index function.
- Sub-module `arb_pick`: combinational. Inputs are a request vector, an exclusion mask, a start pointer and a mode. Outputs are the winner index and a found flag. It is instantiated once.

## Test plan
- **Fixed-mode priority:** `N_CH`=16, fixed mode, `requestSignals`=16'h8014 from IDLE → one cycle later `grantSignals`=16'h0004 and `grantIndex`=2. Then drop bit 2 → next cycle `grantIndex`=4 with no bubble.
- **Round-robin rotation:** round-robin mode, all 16 requests held high, each owner drops for 1 cycle after being granted → owners 0,1,…,15,0. `rrPtr` wraps 15→0.
- **Hold lock:** owner 5 holds while request 0 asserts → grant stays 5. Drop 5 → grant 0 the next cycle. Drop all → `grantValid`=0 the next cycle.
- **Timeout (`ARB_HOLD_TIMEOUT_EN`, `HOLD_MAX`=4):**
  - Channel 3 holds and channel 7 requests → after 4 GRANT cycles, `timeoutPulse`=1 and grant moves to 7.
  - Channel 3 alone → never revoked.
- **Mid-hold reset:** assert `Reset` asynchronously between edges while holding channel 9 → `grantSignals`=0 immediately. After release, round-robin with 16'h0300 grants 8 (`rrPtr`=0).
- **Non-power-of-2 width:** `N_CH`=5, round-robin, requests 5'b10001 → grants alternate 0,4,0,4. IW=3.

Source files
------------

// File: rtl/priority_arbiter_pkg.sv
// priority_arbiter_pkg: shared state type and index helpers for the arbiter
package priority_arbiter_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  localparam int MAX_CH = 256;
  function automatic int idx_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int onehot_to_idx(input logic [MAX_CH-1:0] v);
    int r = 0;
    for (int i = 0; i < MAX_CH; i++) if (v[i]) r |= i;
    return r;
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: finds the first live request, from 0 (fixed) or from start (round-robin)
module arb_pick #(
  parameter int N_CH = 16,
  parameter int IW   = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] excl,
  input  logic [IW-1:0]   start,
  input  logic            rr,
  output logic [IW-1:0]   idx,
  output logic            found
);
  logic [N_CH-1:0] live;
  int base;
  assign live  = req & ~excl;
  assign found = |live;
  assign base  = rr ? int'(start) : 0;
  // Walk offsets downward so the nearest hit to base is written last
  always_comb begin
    idx = '0;
    for (int j = N_CH - 1; j >= 0; j--)
      if (live[(base + j) % N_CH]) idx = IW'((base + j) % N_CH);
  end
endmodule

// File: rtl/priority_arbiter.sv
// priority_arbiter: registered N-channel fixed/round-robin arbiter with grant lock.
// Define ARB_HOLD_TIMEOUT_EN to revoke holds longer than HOLD_MAX when others wait.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int N_CH     = 16,
  parameter int HOLD_MAX = 64
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [N_CH-1:0]          requestSignals,
  input  logic                     roundRobin,
  output logic [N_CH-1:0]          grantSignals,
  output logic                     grantValid,
  output logic [idx_w(N_CH)-1:0]   grantIndex,
  output logic                     timeoutPulse
);
  localparam int IW = idx_w(N_CH);
  state_e state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d, excl;
  logic [IW-1:0] ptr_q, ptr_d, win;
  logic found, owner_req, timeout;
  assign owner_req = |(requestSignals & grant_q);
  assign excl      = timeout ? grant_q : '0;
  arb_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .req(requestSignals), .excl(excl), .start(ptr_q), .rr(roundRobin),
    .idx(win), .found(found)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE || !owner_req || timeout) begin
      state_d = found ? GRANT : IDLE;
      grant_d = found ? ({{(N_CH-1){1'b0}}, 1'b1} << win) : '0;
      ptr_d   = !found ? ptr_q : (win == IW'(N_CH - 1)) ? '0 : win + 1'b1;
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q;
  assign timeout = state_q == GRANT && owner_req &&
                   |(requestSignals & ~grant_q) && cnt_q == CW'(HOLD_MAX);
  assign cnt_d   = (state_q == IDLE || grant_d != grant_q) ? '0 :
                   (cnt_q == CW'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= timeout;
    end
  assign timeoutPulse = to_q;
`else
  localparam int UNUSED_HOLD = HOLD_MAX;
  assign timeout      = 1'b0;
  assign timeoutPulse = 1'b0;
`endif
  assign grantSignals = grant_q;
  assign grantValid   = state_q == GRANT;
  assign grantIndex   = IW'(onehot_to_idx(MAX_CH'(grant_q)));
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: 16- and 5-channel arbiters against an owner/pointer model plus directed literals
module tb_priority_arbiter;
  localparam int HOLD = 4;
  logic clk = 0, rst = 1, rr16 = 0, rr5 = 0;
  logic [15:0] req16 = '0;
  logic [4:0]  req5 = '0;
  logic [15:0] g16; logic v16, t16; logic [3:0] i16;
  logic [4:0]  g5;  logic v5, t5;   logic [2:0] i5;
  int pass_n = 0, total_n = 0;
  int o16 = -1, p16 = 0, h16 = 0, o5 = -1, p5 = 0, h5 = 0;
  bit pl16 = 0, pl5 = 0;

  always #5 clk = ~clk;

  priority_arbiter #(.N_CH(16), .HOLD_MAX(HOLD)) dut16 (
    .Clk(clk), .Reset(rst), .requestSignals(req16), .roundRobin(rr16),
    .grantSignals(g16), .grantValid(v16), .grantIndex(i16), .timeoutPulse(t16));
  priority_arbiter #(.N_CH(5), .HOLD_MAX(HOLD)) dut5 (
    .Clk(clk), .Reset(rst), .requestSignals(req5), .roundRobin(rr5),
    .grantSignals(g5), .grantValid(v5), .grantIndex(i5), .timeoutPulse(t5));

  task automatic chk(input string nm, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Owner is an int (-1 = nobody); winner found by scanning candidates in priority order
  task automatic mstep(input int n, input logic [15:0] req, input bit rr,
                       inout int owner, inout int ptr, inout int held, output bit pulse);
    bit arb;
    int excl, w, c;
    pulse = 0; excl = -1; w = -1;
    arb = (owner < 0) ? 1'b1 : !req[owner];
`ifdef ARB_HOLD_TIMEOUT_EN
    begin
      bit others;
      others = 0;
      for (int i = 0; i < n; i++) if (req[i] && i != owner) others = 1;
      if (!arb && held >= HOLD && others) begin arb = 1; excl = owner; pulse = 1; end
    end
`endif
    if (arb) begin
      for (int k = 0; k < n; k++) begin
        c = rr ? (ptr + k) % n : k;
        if (w < 0 && c != excl && req[c]) w = c;
      end
      owner = w; held = 0;
      if (w >= 0) ptr = (w + 1) % n;
    end else if (held < HOLD) held++;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      o16 = -1; p16 = 0; h16 = 0; pl16 = 0;
      o5 = -1;  p5 = 0;  h5 = 0;  pl5 = 0;
    end else begin
      mstep(16, req16, rr16, o16, p16, h16, pl16);
      mstep(5, {11'b0, req5}, rr5, o5, p5, h5, pl5);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_grant16", g16, o16 < 0 ? 0 : (1 << o16));
    chk("m_valid16", v16, int'(o16 >= 0));
    chk("m_index16", i16, o16 < 0 ? 0 : o16);
    chk("m_pulse16", t16, int'(pl16));
    chk("m_grant5", g5, o5 < 0 ? 0 : (1 << o5));
    chk("m_valid5", v5, int'(o5 >= 0));
    chk("m_index5", i5, o5 < 0 ? 0 : o5);
    chk("m_pulse5", t5, int'(pl5));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_valid", v16, 0); chk("rst_grant", g16, 0); chk("rst_index", i16, 0);
    rst = 0;
    req16 = 16'h8014; step(); chk("fix_grant", g16, 16'h0004); chk("fix_idx", i16, 2);
    req16 = 16'h8010; step(); chk("fix_handoff", i16, 4); chk("fix_nobubble", v16, 1);
    req16 = 16'h0000; step(); chk("fix_idle", v16, 0);
    req16 = 16'h0020; step(); chk("hold_own", i16, 5);
    req16 = 16'h0021; repeat (2) step(); chk("hold_lock", i16, 5);
    req16 = 16'h0001; step(); chk("hold_release", i16, 0);
    req16 = 16'h0000; step(); chk("hold_idle", v16, 0);
    req16 = 16'h0200; step(); chk("rst_hold9", i16, 9);
    #2 rst = 1; #1 chk("async_grant", g16, 0); chk("async_valid", v16, 0);
    step(); rst = 0;
    rr16 = 1; req16 = 16'h0300; step(); chk("rr_after_rst", i16, 8);
    req16 = 16'h0000; step();
    rst = 1; step(); rst = 0;
    req16 = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      step(); chk("rr_rot", i16, k % 16);
      req16 = ~(16'h0001 << (k % 16));
    end
    req16 = 16'h0000; step(); chk("rr_idle", v16, 0);
    rr5 = 1;
    req5 = 5'b10001; step(); chk("n5_a", i5, 0);
    req5 = 5'b10000; step(); chk("n5_b", i5, 4);
    req5 = 5'b00011; step(); chk("n5_wrap", i5, 0);
    req5 = 5'b10010; step(); chk("n5_c", i5, 1);
    req5 = 5'b10001; step(); chk("n5_d", i5, 4);
    req5 = 5'b00011; step(); chk("n5_wrap2", i5, 0);
    req5 = 5'b00000; step();
    rr16 = 0; req16 = 16'h0008; step(); chk("to_own", i16, 3);
    req16 = 16'h0088;
    repeat (4) begin step(); chk("to_hold", i16, 3); chk("to_quiet", t16, 0); end
    step();
`ifdef ARB_HOLD_TIMEOUT_EN
    chk("to_pulse", t16, 1); chk("to_move", i16, 7);
`else
    chk("to_pulse", t16, 0); chk("to_move", i16, 3);
`endif
    step(); chk("to_pulse_once", t16, 0);
    req16 = 16'h0008; step(); chk("to_alone", i16, 3);
    repeat (10) step();
    chk("to_never", i16, 3); chk("to_never_pulse", t16, 0);
    req16 = 16'h0000; step(); chk("end_idle", v16, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
